// File: rtl/handshake_rx_ctrl.sv
// ---------------------------------------------------------------------------
// handshake_rx_ctrl
//   Receive side of a 4-phase req/ack clock-domain-crossing handshake, living
//   in the rd_clk domain. The wr_req level is synchronised. The wr_data word is
//   captured once the request is seen and is offered downstream on a
//   valid/ready interface. rd_ack is returned to the writer only after the
//   word is consumed, so no word is lost or duplicated.
//
// Ports
//   rd_clk     in   receive-domain clock, all state on rising edge
//   rd_reset   in   asynchronous active-low reset
//   wr_req     in   request level from write domain (asynchronous)
//   wr_data    in   write-domain data word, held stable by the writer
//   rd_ack     out  acknowledge level to write domain (flop output)
//   rd_data    out  captured word
//   rd_valid   out  rd_data holds an unconsumed word
//   rd_ready   in   downstream accepts when rd_valid & rd_ready at an edge
//   xfer_cnt   out  completed transfers, wraps modulo 2^CNT_WIDTH
//   proto_err  out  sticky: request withdrawn before acknowledge
// ---------------------------------------------------------------------------
module handshake_rx_ctrl #(
  parameter int unsigned DATA_WIDTH  = 12,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_reset,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_ack,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [CNT_WIDTH-1:0]  xfer_cnt,
  output logic                  proto_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  req_sync;
  logic                    req_s;

  logic                    ack_d;
  logic                    valid_d;
  logic [DATA_WIDTH-1:0]   data_d;
  logic [CNT_WIDTH-1:0]    cnt_d;
  logic                    err_d;

  // -------------------------------------------------------------------------
  // wr_req synchroniser; stage 0 is the only flop that sees the async input.
  // -------------------------------------------------------------------------
  always_ff @(posedge rd_clk or negedge rd_reset) begin
    if (!rd_reset) begin
      req_sync <= '0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], wr_req};
    end
  end

  assign req_s = req_sync[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // State and output registers. rd_ack and rd_valid are flops so the
  // write domain never sees a combinational glitch on the acknowledge.
  // -------------------------------------------------------------------------
  always_ff @(posedge rd_clk or negedge rd_reset) begin
    if (!rd_reset) begin
      state_q   <= IDLE;
      rd_ack    <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      xfer_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_ack    <= ack_d;
      rd_valid  <= valid_d;
      rd_data   <= data_d;
      xfer_cnt  <= cnt_d;
      proto_err <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic.
  //   IDLE captures only on req_s=1 and ACK leaves only on req_s=0, so a
  //   request held high yields exactly one word.
  //   wr_data is sampled solely on the IDLE->VALID step; the writer keeps it
  //   stable from before wr_req rises, so it has settled by the time req_s
  //   is seen.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ack_d   = rd_ack;
    valid_d = rd_valid;
    data_d  = rd_data;
    cnt_d   = xfer_cnt;
    err_d   = proto_err;

    unique case (state_q)
      IDLE: begin
        ack_d   = 1'b0;
        valid_d = 1'b0;
        if (req_s) begin
          data_d  = wr_data;
          valid_d = 1'b1;
          state_d = VALID;
        end
      end

      VALID: begin
        ack_d   = 1'b0;
        valid_d = 1'b1;
        // Request withdrawn before acknowledge: flag it, but still deliver
        // the word. ACK then exits right away because req_s is already low.
        if (!req_s) begin
          err_d = 1'b1;
        end
        if (rd_ready) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          cnt_d   = xfer_cnt + CNT_WIDTH'(1);
          state_d = ACK;
        end
      end

      ACK: begin
        ack_d   = 1'b1;
        valid_d = 1'b0;
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        ack_d   = 1'b0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_handshake_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_handshake_rx_ctrl
//   Directed-plus-random bench for handshake_rx_ctrl. A default instance
//   (CNT_WIDTH=16) and a CNT_WIDTH=4 instance share all stimulus. Expected
//   behaviour comes from the handshake timing rules (cycle counts), an
//   integer transfer count and queues of words that should be delivered.
// ---------------------------------------------------------------------------
module tb_handshake_rx_ctrl;

  localparam int unsigned DW   = 12;
  localparam int unsigned SYNC = 2;

  logic          rd_clk = 1'b0;
  logic          rd_reset;
  logic          wr_req;
  logic [DW-1:0] wr_data;
  logic          rd_ready;

  logic          rd_ack,   rd_ack4;
  logic [DW-1:0] rd_data,  rd_data4;
  logic          rd_valid, rd_valid4;
  logic [15:0]   xfer_cnt;
  logic [3:0]    xfer_cnt4;
  logic          proto_err, proto_err4;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned exp_cnt  = 0;
  logic        exp_err  = 1'b0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];

  handshake_rx_ctrl #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC), .CNT_WIDTH(16)) dut (
    .rd_clk   (rd_clk),
    .rd_reset (rd_reset),
    .wr_req   (wr_req),
    .wr_data  (wr_data),
    .rd_ack   (rd_ack),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .xfer_cnt (xfer_cnt),
    .proto_err(proto_err)
  );

  handshake_rx_ctrl #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC), .CNT_WIDTH(4)) dut4 (
    .rd_clk   (rd_clk),
    .rd_reset (rd_reset),
    .wr_req   (wr_req),
    .wr_data  (wr_data),
    .rd_ack   (rd_ack4),
    .rd_data  (rd_data4),
    .rd_valid (rd_valid4),
    .rd_ready (rd_ready),
    .xfer_cnt (xfer_cnt4),
    .proto_err(proto_err4)
  );

  always #5 rd_clk = ~rd_clk;

  // Record every downstream beat actually taken by the consumer.
  always @(posedge rd_clk) begin
    if (rd_reset && rd_valid && rd_ready) got_q.push_back(rd_data);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  // One full 4-phase transfer from the writer's point of view.
  // stall: cycles rd_ready is held low once rd_valid is up.
  // corrupt: writer illegally changes wr_data during the stall.
  task automatic xfer(input logic [DW-1:0] d, input int unsigned stall, input bit corrupt);
    wr_data  = d;
    wr_req   = 1'b1;
    rd_ready = 1'($urandom_range(0, 1));
    for (int i = 0; i < SYNC; i++) begin
      tick();
      check("pre_valid", rd_valid, 0);
    end
    tick();
    check("valid_rise", rd_valid, 1);
    check("cap_data", rd_data, d);
    check("ack_before_accept", rd_ack, 0);
    for (int unsigned i = 0; i < stall; i++) begin
      rd_ready = 1'b0;
      if (corrupt) wr_data = 12'h123;
      tick();
      check("stall_valid", rd_valid, 1);
      check("stall_data", rd_data, d);
      check("stall_ack", rd_ack, 0);
    end
    rd_ready = 1'b1;
    tick();
    exp_cnt++;
    exp_q.push_back(d);
    check("accept_ack", rd_ack, 1);
    check("accept_valid", rd_valid, 0);
    check("xfer_cnt", xfer_cnt, exp_cnt % 65536);
    check("xfer_cnt4", xfer_cnt4, exp_cnt % 16);
    check("proto_err", proto_err, exp_err);
    wr_req   = 1'b0;
    wr_data  = DW'($urandom);
    rd_ready = 1'($urandom_range(0, 1));
    for (int i = 0; i < SYNC; i++) begin
      tick();
      check("ack_hold", rd_ack, 1);
    end
    tick();
    check("ack_fall", rd_ack, 0);
    check("idle_valid", rd_valid, 0);
  endtask

  initial begin
    int unsigned beats0;

    rd_reset = 1'b0;
    wr_req   = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;

    // Reset state
    #3;
    check("rst_ack", rd_ack, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    check("rst_cnt", xfer_cnt, 0);
    check("rst_err", proto_err, 0);
    tick();
    tick();
    rd_reset = 1'b1;
    tick();

    // Basic transfer, then backpressure with illegal data change
    xfer(12'hA5C, 0, 1'b0);
    xfer(12'hA5C, 10, 1'b1);

    // Back-to-back transfers of 0..7 with random stalls
    beats0 = got_q.size();
    for (int v = 0; v < 8; v++) xfer(DW'(v), $urandom_range(0, 3), 1'b0);
    check("b2b_beats", got_q.size() - beats0, 8);
    check("b2b_cnt", xfer_cnt, 10);
    check("b2b_err", proto_err, 0);

    // Random words
    for (int n = 0; n < 10; n++) xfer(DW'($urandom), $urandom_range(0, 5), 1'b0);

    // Held request: exactly one word, ack stays high
    beats0   = got_q.size();
    wr_data  = 12'h3C7;
    wr_req   = 1'b1;
    rd_ready = 1'b1;
    for (int i = 0; i < SYNC; i++) tick();
    tick();
    check("held_valid", rd_valid, 1);
    tick();
    exp_cnt++;
    exp_q.push_back(12'h3C7);
    check("held_ack", rd_ack, 1);
    for (int i = 0; i < 50; i++) begin
      tick();
      check("held_ack_stay", rd_ack, 1);
      check("held_no_valid", rd_valid, 0);
    end
    check("held_beats", got_q.size() - beats0, 1);
    check("held_cnt", xfer_cnt, exp_cnt % 65536);
    wr_req = 1'b0;
    for (int i = 0; i < SYNC; i++) tick();
    tick();
    check("held_ack_fall", rd_ack, 0);

    // Protocol error: request dropped while word pending
    wr_data  = 12'h5E1;
    wr_req   = 1'b1;
    rd_ready = 1'b0;
    for (int i = 0; i < SYNC; i++) tick();
    tick();
    check("perr_valid", rd_valid, 1);
    wr_req = 1'b0;
    for (int i = 0; i < SYNC + 1; i++) begin
      tick();
      check("perr_valid_hold", rd_valid, 1);
    end
    check("perr_flag", proto_err, 1);
    exp_err  = 1'b1;
    rd_ready = 1'b1;
    tick();
    exp_cnt++;
    exp_q.push_back(12'h5E1);
    check("perr_ack_pulse", rd_ack, 1);
    check("perr_cnt", xfer_cnt, exp_cnt % 65536);
    tick();
    check("perr_ack_low", rd_ack, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("perr_idle_valid", rd_valid, 0);
      check("perr_sticky", proto_err, 1);
    end
    xfer(12'h0F0, 1, 1'b0);

    // Reset while VALID, request still high afterwards
    wr_data  = 12'h9AB;
    wr_req   = 1'b1;
    rd_ready = 1'b0;
    for (int i = 0; i < SYNC; i++) tick();
    tick();
    check("rstv_valid", rd_valid, 1);
    #3;
    rd_reset = 1'b0;
    #1;
    check("async_ack", rd_ack, 0);
    check("async_valid", rd_valid, 0);
    check("async_data", rd_data, 0);
    check("async_cnt", xfer_cnt, 0);
    check("async_cnt4", xfer_cnt4, 0);
    check("async_err", proto_err, 0);
    exp_cnt = 0;
    exp_err = 1'b0;
    tick();
    rd_reset = 1'b1;
    xfer(12'h9AB, 0, 1'b0);

    // Counter wrap on the 4-bit instance: 17 transfers since reset
    for (int n = 0; n < 16; n++) xfer(DW'($urandom), $urandom_range(0, 2), 1'b0);
    check("wrap_cnt4", xfer_cnt4, 1);
    check("wrap_cnt16", xfer_cnt, 17);

    // Every delivered word, in order
    check("total_beats", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("beat_word", got_q[i], exp_q[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
